sha_nonce_dispatcher: RTL

- Sits directly upstream of the SHA-256 round core.
- Accepts one work unit: a 256-bit midstate plus the 96-bit header tail. Scans an inclusive nonce range and builds each padded 512-bit second-chunk block.
- Issues one block to the core at a time and captures the returned hash. Compares the hash against a leading-zero target and reports golden nonces to the host-side interface.

---
 rtl/sha_nonce_dispatcher_pkg.sv | 30 +++
 rtl/sha_target_check.sv | 16 +
 rtl/sha_nonce_dispatcher.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sha_nonce_dispatcher_pkg.sv
// Shared definitions for the nonce dispatcher: FSM encodings, padding words,
// header field widths and the second-chunk block packer.
package sha_nonce_dispatcher_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_CHECK = 2'd3;

    localparam int unsigned MIDSTATE_W  = 256;
    localparam int unsigned TAIL_W      = 96;
    localparam int unsigned NONCE_W     = 32;
    localparam int unsigned HASH_W      = 256;
    localparam int unsigned BLOCK_W     = 512;
    localparam int unsigned ZERO_FILL_W = BLOCK_W - TAIL_W - 3 * NONCE_W;

    localparam logic [31:0] PAD_WORD = 32'h80000000;
    localparam logic [31:0] LEN_WORD = 32'h00000280;

    // Word 0 of the block lands at [511:480]; the length word closes the block.
    function automatic logic [BLOCK_W-1:0] pack_block(
        input logic [TAIL_W-1:0]  tail,
        input logic [NONCE_W-1:0] nonce
    );
        return {tail, nonce, PAD_WORD, {ZERO_FILL_W{1'b0}}, LEN_WORD};
    endfunction

endpackage

// File: rtl/sha_target_check.sv
// Combinational leading-zero target comparator: hit when the TARGET_ZEROS
// most-significant hash bits are all zero.
module sha_target_check
    import sha_nonce_dispatcher_pkg::*;
#(
    parameter int unsigned TARGET_ZEROS = 32
) (
    input  logic [HASH_W-1:0] hash,
    output logic              hit
);

    localparam logic [HASH_W-1:0] TARGET_MASK = ~({HASH_W{1'b1}} >> TARGET_ZEROS);

    assign hit = ((hash & TARGET_MASK) == '0);

endmodule

// File: rtl/sha_nonce_dispatcher.sv
// Nonce-range dispatcher feeding the SHA-256 round core and reporting golden
// nonces. Optional hash_count statistics port under SHA_DISPATCH_STATS_EN.
module sha_nonce_dispatcher
    import sha_nonce_dispatcher_pkg::*;
#(
    parameter logic [31:0] NONCE_STEP   = 32'd1,
    parameter int unsigned TARGET_ZEROS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  work_valid,
    output logic                  work_ready,
    input  logic [MIDSTATE_W-1:0] work_midstate,
    input  logic [TAIL_W-1:0]     work_tail,
    input  logic [NONCE_W-1:0]    nonce_start,
    input  logic [NONCE_W-1:0]    nonce_end,
    output logic                  core_start,
    output logic [BLOCK_W-1:0]    core_data,
    output logic [MIDSTATE_W-1:0] core_midstate,
    output logic                  core_midstate_en,
    input  logic                  core_done,
    input  logic [HASH_W-1:0]     core_hash,
    output logic                  golden_valid,
    output logic [NONCE_W-1:0]    golden_nonce,
    output logic                  scan_done
`ifdef SHA_DISPATCH_STATS_EN
    ,
    output logic [31:0]           hash_count
`endif
);

    state_t                state;
    logic [MIDSTATE_W-1:0] midstate_q;
    logic [TAIL_W-1:0]     tail_q;
    logic [NONCE_W-1:0]    nonce_q;
    logic [NONCE_W-1:0]    end_q;
    logic [HASH_W-1:0]     hash_q;
    logic                  hit;
    logic                  last_nonce;

    sha_target_check #(
        .TARGET_ZEROS(TARGET_ZEROS)
    ) u_target_check (
        .hash(hash_q),
        .hit (hit)
    );

    // The ordering term makes a start-above-end range issue a single block
    // instead of scanning through the 32-bit wrap.
    assign last_nonce = ((end_q - nonce_q) < NONCE_STEP) || (nonce_q > end_q);

    assign work_ready       = (state == S_IDLE);
    assign core_start       = (state == S_ISSUE);
    assign core_data        = pack_block(tail_q, nonce_q);
    assign core_midstate    = midstate_q;
    assign core_midstate_en = 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= S_IDLE;
            midstate_q   <= '0;
            tail_q       <= '0;
            nonce_q      <= '0;
            end_q        <= '0;
            hash_q       <= '0;
            golden_valid <= 1'b0;
            golden_nonce <= '0;
            scan_done    <= 1'b0;
        end else begin
            golden_valid <= 1'b0;
            scan_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (work_valid) begin
                        midstate_q <= work_midstate;
                        tail_q     <= work_tail;
                        nonce_q    <= nonce_start;
                        end_q      <= nonce_end;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        hash_q <= core_hash;
                        state  <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (hit) begin
                        golden_valid <= 1'b1;
                        golden_nonce <= nonce_q;
                    end
                    if (last_nonce) begin
                        scan_done <= 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        nonce_q <= nonce_q + NONCE_STEP;
                        state   <= S_ISSUE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SHA_DISPATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            hash_count <= '0;
        end else if (state == S_CHECK) begin
            hash_count <= hash_count + 32'd1;
        end
    end
`endif

endmodule
